// File: rtl/seven_seg_display.sv
// Multiplexed 8-digit common-anode seven-segment driver for the two Pong scores.
// Each score is shown as two decimal digits. Right score uses digits 1:0, left score uses digits 7:6.
module seven_seg_display #(
    parameter int unsigned REFRESH_BITS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rightPlayerScore,
    input  logic [3:0] leftPlayerScore,
    output logic [7:0] anode,
    output logic [7:0] cathode
);

    localparam logic [7:0] BLANK = 8'hFF;

    typedef enum logic [2:0] {
        DIG_RIGHT_ONES = 3'd0,
        DIG_RIGHT_TENS = 3'd1,
        DIG_LEFT_ONES  = 3'd6,
        DIG_LEFT_TENS  = 3'd7
    } digit_e;

    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [2:0]              sel;

    logic       right_tens_on;
    logic       left_tens_on;
    logic [3:0] right_ones;
    logic [3:0] left_ones;

    logic [7:0] next_anode;
    logic [7:0] next_cathode;

    // Active-low segment patterns {dp,g,f,e,d,c,b,a}; dp is never lit.
    function automatic logic [7:0] seg_code(input logic [3:0] digit);
        logic [7:0] code;
        code = BLANK;
        case (digit)
            4'd0: code = 8'hC0;
            4'd1: code = 8'hF9;
            4'd2: code = 8'hA4;
            4'd3: code = 8'hB0;
            4'd4: code = 8'h99;
            4'd5: code = 8'h92;
            4'd6: code = 8'h82;
            4'd7: code = 8'hF8;
            4'd8: code = 8'h80;
            4'd9: code = 8'h90;
            default: code = BLANK;
        endcase
        return code;
    endfunction

    assign sel = refresh_cnt[REFRESH_BITS-1 -: 3];

    // Scores never exceed 15, so a single compare-and-subtract gives the decimal split.
    assign right_tens_on = (rightPlayerScore >= 4'd10);
    assign left_tens_on  = (leftPlayerScore  >= 4'd10);
    assign right_ones    = right_tens_on ? (rightPlayerScore - 4'd10) : rightPlayerScore;
    assign left_ones     = left_tens_on  ? (leftPlayerScore  - 4'd10) : leftPlayerScore;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        next_anode   = BLANK;
        next_cathode = BLANK;
        case (sel)
            DIG_RIGHT_ONES: begin
                next_anode   = ~(8'b1 << sel);
                next_cathode = seg_code(right_ones);
            end
            DIG_RIGHT_TENS: begin
                next_anode   = ~(8'b1 << sel);
                next_cathode = right_tens_on ? seg_code(4'd1) : BLANK;
            end
            DIG_LEFT_ONES: begin
                next_anode   = ~(8'b1 << sel);
                next_cathode = seg_code(left_ones);
            end
            DIG_LEFT_TENS: begin
                next_anode   = ~(8'b1 << sel);
                next_cathode = left_tens_on ? seg_code(4'd1) : BLANK;
            end
            default: begin
                next_anode   = BLANK;
                next_cathode = BLANK;
            end
        endcase
    end

    // A blank tens digit still has its anode enabled, so each active digit gets a uniform duty cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            anode       <= BLANK;
            cathode     <= BLANK;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            refresh_cnt <= refresh_cnt + 1'b1;
            anode       <= next_anode;
            cathode     <= next_cathode;
        end
    end

endmodule

// File: tb/tb_seven_seg_display.sv
// Directed self-checking bench for seven_seg_display with REFRESH_BITS=6, giving 8 clocks per digit.
module tb_seven_seg_display;

    logic       clk;
    logic       rst_n;
    logic [3:0] right_score;
    logic [3:0] left_score;
    logic [7:0] anode;
    logic [7:0] cathode;

    int vectors;
    int miscompares;
    int edges;

    seven_seg_display #(.REFRESH_BITS(6)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rightPlayerScore (right_score),
        .leftPlayerScore  (left_score),
        .anode            (anode),
        .cathode          (cathode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_seg(input int d);
        logic [7:0] table_v [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                     8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return table_v[d];
    endfunction

    // Digit shown after the n-th edge since release: the counter held n-1 before that edge.
    function automatic int sel_of(input int n);
        return ((n - 1) / 8) % 8;
    endfunction

    function automatic logic [7:0] exp_anode(input int s);
        case (s)
            0: return 8'hFE;
            1: return 8'hFD;
            6: return 8'hBF;
            7: return 8'h7F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] exp_cathode(input int s, input int r, input int l);
        case (s)
            0: return ref_seg(r % 10);
            1: return (r >= 10) ? 8'hF9 : 8'hFF;
            6: return ref_seg(l % 10);
            7: return (l >= 10) ? 8'hF9 : 8'hFF;
            default: return 8'hFF;
        endcase
    endfunction

    // Advance n edges and check both outputs on the following falling edge.
    task automatic run(input int n, input string tag);
        logic [7:0] low_cnt;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            check({tag, "_anode"}, anode, exp_anode(sel_of(edges)));
            check({tag, "_cathode"}, cathode,
                  exp_cathode(sel_of(edges), int'(right_score), int'(left_score)));
            low_cnt = 8'($countones(~anode));
            check({tag, "_onehot"}, {7'd0, (low_cnt <= 8'd1)}, 8'd1);
            check({tag, "_dp"}, {7'd0, cathode[7]}, 8'd1);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        edges       = 0;
        rst_n       = 1'b1;
        right_score = 4'd0;
        left_score  = 4'd0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_async_anode", anode, 8'hFF);
        check("rst_async_cathode", cathode, 8'hFF);
        repeat (2) @(negedge clk);
        check("rst_hold_anode", anode, 8'hFF);
        check("rst_hold_cathode", cathode, 8'hFF);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
        run(1, "first_edge");
        check("first_anode_fe", anode, 8'hFE);
        check("first_cathode_c0", cathode, 8'hC0);
        run(8, "digit1");
        check("digit1_anode_fd", anode, 8'hFD);
        check("digit1_cathode_ff", cathode, 8'hFF);
        run(55, "zero_frame");

        right_score = 4'd1;
        left_score  = 4'd2;
        run(64, "r1_l2");

        right_score = 4'd15;
        left_score  = 4'd10;
        run(64, "r15_l10");

        for (int v = 0; v < 16; v++) begin
            right_score = 4'(v);
            left_score  = 4'(15 - v);
            run(64, $sformatf("sweep%0d", v));
        end

        // Mid-scan score change: the next edge must already reflect the new value.
        for (int i = 0; i < 64 && sel_of(edges + 1) != 0; i++) run(1, "align0");
        right_score = 4'd7;
        run(4, "mid_change_a");
        right_score = 4'd12;
        run(12, "mid_change_b");

        for (int i = 0; i < 64 && sel_of(edges) != 5; i++) run(1, "align5");
        check("in_sel5_anode", anode, 8'hFF);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_async_anode", anode, 8'hFF);
        check("midrst_async_cathode", cathode, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_hold_anode", anode, 8'hFF);
            check("midrst_hold_cathode", cathode, 8'hFF);
        end
        rst_n = 1'b1;
        edges = 0;
        right_score = 4'd3;
        left_score  = 4'd9;
        run(1, "restart");
        check("restart_anode_fe", anode, 8'hFE);
        check("restart_cathode_b0", cathode, 8'hB0);
        run(63, "restart_frame");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
